lsu: RTL and testbench
======================

# lsu

Load/store unit between the execute stage and `dmem`. Accepts one memory operation at a time from execute and drives `dmem`'s address, enable, size and write-data inputs. For loads, waits for `dmem`'s `ready`, then sign- or zero-extends the returned data and presents a one-cycle writeback response. Also flags illegal encodings, read timeouts and, optionally, misaligned accesses.

## Interface
- `TIMEOUT`, default 15: maximum cycles in RD_WAIT without `mem_ready` before the load is answered with an error.
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute presents an operation.
- `req_ready`  out  1  `(state==IDLE) && !reset`.
- `req_load`  in  1  1 = load, 0 = store.
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  `ADDR_SIZE`+1  byte address.
- `req_wdata`  in  `INSTR_SIZE`+1  store data.
- `req_rd`  in  5  destination register tag.
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_data`  out  `INSTR_SIZE`+1  extended load data; 0 for stores and errors.
- `resp_rd`  out  5  tag; 0 for stores.
- `resp_err`  out  1  illegal op, timeout or misalign.
- `mem_addr`  out  `ADDR_SIZE`+1  to `dmem` `addr`.
- `mem_r_enable`  out  1  to `dmem` `r_enable`.
- `mem_w_enable`  out  1  to `dmem` `w_enable`.
- `mem_w_size`  out  2  to `dmem` `w_size`: 00 byte, 01 half, 10 word.
- `mem_w_data`  out  `INSTR_SIZE`+1  to `dmem` `w_data`.
- `mem_r_data`  in  `INSTR_SIZE`+1  from `dmem` `r_data`.
- `mem_ready`  in  1  from `dmem` `ready`.

## Operation
- **States.** IDLE, RD_ISSUE, RD_WAIT, WR, RESP.
- **Accept.** An operation is accepted on a `clk` edge where `req_valid && req_ready`.
  - On accept, latch addr, wdata, funct3, rd and load into registers.
  - `mem_addr` and `mem_w_data` come from these registers and stay stable until the next accept.
- **Load path.** IDLE → RD_ISSUE → RD_WAIT.
  - RD_ISSUE: `mem_r_enable`=1 for exactly one cycle.
  - RD_WAIT: `mem_r_enable`=0; wait for `mem_ready`.
  - On `mem_ready`, capture the extended `mem_r_data` into `resp_data` and go to RESP.
- **Store path.** IDLE → WR → RESP.
  - WR: `mem_w_enable`=1 for exactly one cycle.
  - `mem_w_size` = `funct3[1:0]`.
  - `mem_w_data` = raw `req_wdata`; `dmem` rotates the byte lanes itself.
- **RESP.** `resp_valid`=1 for one cycle, then IDLE.
- **Extension.** `dmem` already places the addressed byte in [7:0].
  - 000: sign-extend [7:0].
  - 001: sign-extend [15:0].
  - 010: pass all 32 bits.
  - 100: zero-extend [7:0].
  - 101: zero-extend [15:0].
- **Illegal encodings.** Load funct3 011/110/111, or store funct3 not in {000, 001, 010}.
  - No memory enable is asserted.
  - Path is IDLE → RESP with `resp_err`=1 and `resp_data`=0.
- **Timeout.** A counter of width clog2(TIMEOUT+1) clears on entry to RD_WAIT and increments each RD_WAIT cycle.
  - When the count reaches TIMEOUT, go to RESP with `resp_err`=1 and `resp_data`=0.
  - If `mem_ready` arrives in the same cycle as the timeout, data wins and `resp_err`=0.
- **Ignored inputs.** `mem_ready` outside RD_WAIT is ignored. `req_valid` while busy is ignored; upstream must hold its request.

## Timing
- **Reset.** Next state is IDLE. All outputs reset to 0: `resp_*`, `mem_*`, counter, and `req_ready`.
- **Reset mid-operation.** The operation is abandoned, no response is produced, and the enables are 0 from the next cycle.
- **Load latency** (accept at edge N):
  - `mem_r_enable` high in cycle N+1.
  - `dmem` returns `ready` in cycle N+2.
  - `resp_valid` high in cycle N+3.
  - `req_ready` high again in cycle N+4.
- **Store latency.** `mem_w_enable` high in cycle N+1; `resp_valid` high in cycle N+2.
- **Error latency** (illegal or misaligned). `resp_valid` high in cycle N+1.
- **Output decode.** `mem_r_enable` and `mem_w_enable` are decoded from the state register only, so they have no combinational path from `req_*`.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined.**
  - Misaligned means halfword with `addr[0]`≠0, or word with `addr[1:0]`≠0.
  - Such operations skip memory, take IDLE → RESP, and return `resp_err`=1, `resp_data`=0.
- **`LSU_MISALIGN_TRAP_EN` undefined.** Misaligned operations are issued normally and `dmem` handles lane rotation and word crossing.

## Structure
- **Shared definitions** (alongside `ADDR_SIZE`/`INSTR_SIZE` in `def_params.v`):
  - funct3 constants (`LSU_F3_*`).
  - w_size encodings (`MEM_SIZE_B/H/W`).
  - state encodings.
- **Sub-module** `lsu_load_ext`: combinational funct3 + 32-bit data → extended 32-bit result. The FSM, registers and counter stay in `lsu`.

## Test plan
- **Byte loads.** Word 0x8765_43F1 at 0x10; LB 0x10, rd=5 → `resp_data`=0xFFFF_FFF1, `resp_rd`=5, `resp_valid` 3 cycles after accept. LBU 0x10 → 0x0000_00F1.
- **Halfword loads.** LH 0x12 → 0xFFFF_8765; LHU 0x12 → 0x0000_8765.
- **Store then load.** SW 0xDEAD_BEEF to 0x20 → `mem_w_enable` one cycle, `mem_w_size`=10, `resp_valid` at N+2. LW 0x20 → 0xDEAD_BEEF. SB 0x55 to 0x21, then LW 0x20 → 0xDEAD_55EF.
- **Misalign and illegal.** LW 0x11: with the macro → `resp_err`=1 at N+1 and `mem_r_enable` never high; without it → data returned normally. Load funct3=011 → `resp_err`=1 and no memory enable.
- **Timeout.** `mem_ready` forced to 0 → `resp_err`=1 and `resp_data`=0 after TIMEOUT cycles in RD_WAIT. `mem_ready` asserted exactly on the timeout cycle → data returned with `resp_err`=0.
- **Reset mid-read.** `reset` asserted in RD_WAIT → no `resp_valid` and `req_ready`=0 while `reset` is high. After release, a clean LW 0x10 returns 0x8765_43F1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, funct3 codes,
// dmem size encodings, FSM states and encoding-check helpers.
package lsu_pkg;

  localparam int ADDR_SIZE  = 31;
  localparam int INSTR_SIZE = 31;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR,
    S_RESP
  } lsu_state_e;

  function automatic logic op_legal(
    input logic       load,
    input logic [2:0] f3
  );
    logic ok;
    ok = (f3 == LSU_F3_B) || (f3 == LSU_F3_H)
      || (f3 == LSU_F3_W);
    if (load)
      ok = ok || (f3 == LSU_F3_BU)
        || (f3 == LSU_F3_HU);
    return ok;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic m;
    m = 1'b0;
    if (f3[1:0] == MEM_SIZE_H)
      m = a[0];
    else if (f3[1:0] == MEM_SIZE_W)
      m = |a;
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load-data extender: dmem returns the addressed byte in [7:0];
// this widens it to 32 bits according to funct3.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [INSTR_SIZE:0] data,
  output logic [INSTR_SIZE:0] result
);

  always_comb begin
    result = data;
    case (funct3)
      LSU_F3_B:  result = {{24{data[7]}}, data[7:0]};
      LSU_F3_H:  result = {{16{data[15]}}, data[15:0]};
      LSU_F3_W:  result = data;
      LSU_F3_BU: result = {24'd0, data[7:0]};
      LSU_F3_HU: result = {16'd0, data[15:0]};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and dmem, one op in flight.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W ops.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_load,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_SIZE:0]  req_addr,
  input  logic [INSTR_SIZE:0] req_wdata,
  input  logic [4:0]          req_rd,
  output logic                resp_valid,
  output logic [INSTR_SIZE:0] resp_data,
  output logic [4:0]          resp_rd,
  output logic                resp_err,
  output logic [ADDR_SIZE:0]  mem_addr,
  output logic                mem_r_enable,
  output logic                mem_w_enable,
  output logic [1:0]          mem_w_size,
  output logic [INSTR_SIZE:0] mem_w_data,
  input  logic [INSTR_SIZE:0] mem_r_data,
  input  logic                mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e          state;
  logic [ADDR_SIZE:0]  addr_q;
  logic [INSTR_SIZE:0] wdata_q;
  logic [2:0]          f3_q;
  logic [CW-1:0]       cnt;
  logic [INSTR_SIZE:0] ext_data;
  logic                mis;
  logic                bad_op;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = misaligned(req_funct3, req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign bad_op = !op_legal(req_load, req_funct3) || mis;

  lsu_load_ext u_ext (
    .funct3 (f3_q),
    .data   (mem_r_data),
    .result (ext_data)
  );

  assign req_ready    = (state == S_IDLE) && !reset;
  assign resp_valid   = (state == S_RESP);
  assign mem_r_enable = (state == S_RD_ISSUE);
  assign mem_w_enable = (state == S_WR);
  assign mem_addr     = addr_q;
  assign mem_w_data   = wdata_q;
  assign mem_w_size   = f3_q[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      cnt       <= '0;
      resp_data <= '0;
      resp_rd   <= '0;
      resp_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            f3_q      <= req_funct3;
            resp_rd   <= req_load ? req_rd : 5'd0;
            resp_data <= '0;
            resp_err  <= bad_op;
            if (bad_op)
              state <= S_RESP;
            else if (req_load)
              state <= S_RD_ISSUE;
            else
              state <= S_WR;
          end
        end
        S_RD_ISSUE: begin
          cnt   <= '0;
          state <= S_RD_WAIT;
        end
        // data beats the timeout when both land together
        S_RD_WAIT: begin
          if (mem_ready) begin
            resp_data <= ext_data;
            state     <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            resp_err <= 1'b1;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WR:   state <= S_RESP;
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: bench-side dmem model, queue of expected
// responses filled at accept, independent monitor on resp_valid.
module tb_lsu;
  import lsu_pkg::*;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;
  logic        mem_r_enable, mem_w_enable, mem_ready;
  logic [1:0]  mem_w_size;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_r_enable(mem_r_enable),
    .mem_w_enable(mem_w_enable), .mem_w_size(mem_w_size),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mem [0:255];
  int          total = 0;
  int          bad = 0;
  int          rd_delay = 1;
  int          ren_cnt = 0;
  int          wen_cnt = 0;
  logic [1:0]  exp_wsize;
  logic [31:0] exp_wdata;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(logic [31:0] a);
    return {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[a[7:0]]};
  endfunction

  // Reference: assemble bytes as numbers and apply the signedness rule.
  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    longint b0, b1, b2, b3, v;
    b0 = mem[a[7:0]];
    b1 = mem[8'(a + 1)];
    b2 = mem[8'(a + 2)];
    b3 = mem[8'(a + 3)];
    v = 0;
    case (f3)
      3'd0: begin v = b0; if (v > 127) v -= 256; end
      3'd1: begin v = b0 + 256 * b1; if (v > 32767) v -= 65536; end
      3'd2: v = b0 + 256 * b1 + 65536 * b2 + 16777216 * b3;
      3'd4: v = b0;
      3'd5: v = b0 + 256 * b1;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  // dmem model: ready rd_delay cycles after the read enable (0 = never)
  initial begin
    mem_ready = 1'b0;
    mem_r_data = '0;
    forever begin
      @(negedge clk);
      if (mem_w_enable) begin
        wen_cnt++;
        chk("w_size", 32'(mem_w_size), 32'(exp_wsize));
        chk("w_data", mem_w_data, exp_wdata);
        for (int i = 0; i < (1 << mem_w_size); i++)
          mem[8'(mem_addr + i)] = mem_w_data[8*i +: 8];
      end
      if (mem_r_enable) begin
        ren_cnt++;
        if (rd_delay > 0) begin
          repeat (rd_delay) @(posedge clk);
          #1;
          mem_ready = 1'b1;
          mem_r_data = word_at(mem_addr);
          @(posedge clk);
          #1;
          mem_ready = 1'b0;
        end
      end
    end
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp data=%h rd=%0d err=%b t=%0t",
                   resp_data, resp_rd, resp_err, $time);
        end else begin
          e = sbq.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_rd", 32'(resp_rd), 32'(e.rd));
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(logic ld, logic [2:0] f3, logic [31:0] a,
                       logic [31:0] wd, logic [4:0] rd, output int acc);
    int n;
    @(negedge clk);
    req_load = ld; req_funct3 = f3; req_addr = a;
    req_wdata = wd; req_rd = rd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout req_ready=%b required=1", req_ready);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic op(logic ld, logic [2:0] f3, logic [31:0] a,
                    logic [31:0] wd, logic [4:0] rd, int d);
    exp_t e;
    logic pre_err;
    int r0, w0, acc, n;
    pre_err = !op_legal(ld, f3);
`ifdef LSU_MISALIGN_TRAP_EN
    pre_err = pre_err || misaligned(f3, a[1:0]);
`endif
    e.rd = ld ? rd : 5'd0;
    e.err = pre_err;
    e.data = 0;
    e.lat = 0;
    if (!pre_err) begin
      if (!ld) begin
        e.lat = 1;
      end else if (d == 0 || d > TO) begin
        e.err = 1'b1;
        e.lat = TO + 1;
      end else begin
        e.data = ref_load(f3, a);
        e.lat = d + 1;
      end
    end
    exp_wsize = f3[1:0];
    exp_wdata = wd;
    rd_delay = d;
    r0 = ren_cnt;
    w0 = wen_cnt;
    issue(ld, f3, a, wd, rd, acc);
    e.acc = acc;
    sbq.push_back(e);
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL resp_timeout pending=%0d required=0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge clk);
    chk("r_enable_cnt", 32'(ren_cnt - r0), 32'(ld && !pre_err));
    chk("w_enable_cnt", 32'(wen_cnt - w0), 32'(!ld && !pre_err));
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hF1; mem[8'h11] = 8'h43;
    mem[8'h12] = 8'h65; mem[8'h13] = 8'h87;
    reset = 1'b1;
    req_valid = 1'b0; req_load = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_ren", 32'(mem_r_enable), 32'd0);
    chk("reset_wen", 32'(mem_w_enable), 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    op(1, LSU_F3_B,  32'h10, 0, 5'd5, 1);
    op(1, LSU_F3_BU, 32'h10, 0, 5'd6, 1);
    op(1, LSU_F3_H,  32'h12, 0, 5'd7, 1);
    op(1, LSU_F3_HU, 32'h12, 0, 5'd8, 1);
    op(0, LSU_F3_W,  32'h20, 32'hDEAD_BEEF, 5'd3, 1);
    op(1, LSU_F3_W,  32'h20, 0, 5'd9, 1);
    op(0, LSU_F3_B,  32'h21, 32'h0000_0055, 5'd4, 1);
    op(1, LSU_F3_W,  32'h20, 0, 5'd10, 1);
    op(1, LSU_F3_W,  32'h11, 0, 5'd11, 2);
    op(1, 3'b011,    32'h10, 0, 5'd12, 1);
    op(0, 3'b100,    32'h24, 32'h1234_5678, 5'd13, 1);
    op(1, LSU_F3_W,  32'h10, 0, 5'd14, 0);
    op(1, LSU_F3_W,  32'h10, 0, 5'd15, TO);
    op(1, LSU_F3_H,  32'h10, 0, 5'd16, TO + 1);

    // reset while waiting for a read that never completes
    rd_delay = 0;
    issue(1, LSU_F3_W, 32'h10, 0, 5'd17, acc);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      chk("midrst_ren", 32'(mem_r_enable), 32'd0);
    end
    reset = 1'b0;
    repeat (TO + 4) @(negedge clk);
    op(1, LSU_F3_W, 32'h10, 0, 5'd18, 1);

    for (int k = 0; k < 150; k++)
      op(1'($urandom % 2), 3'($urandom % 8), 32'($urandom % 64),
         $urandom, 5'($urandom % 32), 1 + int'($urandom % 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
